seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx.sv | 123 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Parallel-in, serial-out pattern transmitter for the "two consecutive ones" detector.
// Sends a word MSB first on w and tracks a shadow detector so ExpZ predicts the downstream z.
module seq_pattern_tx #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Data,
   input  logic [LEN_W-1:0] Len,
   output logic             w,
   output logic             Valid,
   output logic             Busy,
   output logic             Done,
   output logic             ExpZ
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      SH_A = 2'b00,
      SH_B = 2'b01,
      SH_C = 2'b10
   } shadow_t;

   localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

   state_t           state_q, state_d;
   shadow_t          shadow_q, shadow_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             w_q, w_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             expz_q, expz_d;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         shadow_q <= SH_A;
         sreg_q   <= '0;
         cnt_q    <= '0;
         w_q      <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         expz_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         w_q      <= w_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         expz_q   <= expz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (Start && (Len != '0)) begin
               sreg_d  = Data;
               cnt_d   = (Len > WIDTH_L) ? WIDTH_L : Len;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - ONE_L;
            if (cnt_q == ONE_L) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they land in flops alongside it.
   always_comb begin
      valid_d = (state_d == SHIFT);
      w_d     = (state_d == SHIFT) && sreg_d[WIDTH-1];
      busy_d  = (state_d == SHIFT) || (state_d == DONE);
      done_d  = (state_d == DONE);
   end

   always_comb begin
      shadow_d = shadow_q;
      unique case (shadow_q)
         SH_A:    shadow_d = w_q ? SH_B : SH_A;
         SH_B:    shadow_d = w_q ? SH_C : SH_A;
         SH_C:    shadow_d = w_q ? SH_C : SH_A;
         default: shadow_d = SH_A;
      endcase
      expz_d = (shadow_d == SH_C);
   end

   assign w     = w_q;
   assign Valid = valid_q;
   assign Busy  = busy_q;
   assign Done  = done_q;
   assign ExpZ  = expz_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx; expected waveforms are hand-computed bit strings.
module tb_seq_pattern_tx;

   logic       Clock;
   logic       Reset;
   logic       Start;
   logic [7:0] Data;
   logic [3:0] Len;
   logic       w;
   logic       Valid;
   logic       Busy;
   logic       Done;
   logic       ExpZ;

   int compareCount;
   int mismatchCount;

   seq_pattern_tx #(.WIDTH(8), .LEN_W(4)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .Start (Start),
      .Data  (Data),
      .Len   (Len),
      .w     (w),
      .Valid (Valid),
      .Busy  (Busy),
      .Done  (Done),
      .ExpZ  (ExpZ)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic [7:0] data, input logic [3:0] len);
      Start = start;
      Data  = data;
      Len   = len;
   endtask

   // Advance past the next rising edge and settle, so samples sit away from the edge.
   task automatic stepCycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic checkCycle(input string tag, input logic ew, input logic ev, input logic eb,
                             input logic ed, input logic ez);
      checkOutput({tag, ".w"},     {31'd0, w},     {31'd0, ew});
      checkOutput({tag, ".Valid"}, {31'd0, Valid}, {31'd0, ev});
      checkOutput({tag, ".Busy"},  {31'd0, Busy},  {31'd0, eb});
      checkOutput({tag, ".Done"},  {31'd0, Done},  {31'd0, ed});
      checkOutput({tag, ".ExpZ"},  {31'd0, ExpZ},  {31'd0, ez});
   endtask

   // Cycle j (1..n) after the accepting edge uses bit [n-j] of each expectation vector.
   task automatic checkWindow(input string tag, input int n, input logic [15:0] expW,
                              input logic [15:0] expV, input logic [15:0] expB,
                              input logic [15:0] expD, input logic [15:0] expZ);
      for (int j = 1; j <= n; j++) begin
         checkCycle($sformatf("%s[k+%0d]", tag, j),
                    expW[n-j], expV[n-j], expB[n-j], expD[n-j], expZ[n-j]);
         stepCycle();
      end
   endtask

   task automatic pulseStart(input logic [7:0] data, input logic [3:0] len);
      applyStimulus(1'b1, data, len);
      stepCycle();
      applyStimulus(1'b0, 8'h00, 4'd0);
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      Reset = 1'b1;
      applyStimulus(1'b0, 8'h00, 4'd0);
      stepCycle();
      stepCycle();
      checkCycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      Reset = 1'b0;
      stepCycle();
      checkCycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] full word 8'hDC len 8");
      pulseStart(8'hDC, 4'd8);
      checkWindow("dc8", 10, 16'b1101110000, 16'b1111111100, 16'b1111111110,
                  16'b0000000010, 16'b0010011000);
      stepCycle();

      $display("[TB] short word 8'hA0 len 3");
      pulseStart(8'hA0, 4'd3);
      checkWindow("a0l3", 6, 16'b101000, 16'b111000, 16'b111100, 16'b000100, 16'b000000);
      stepCycle();

      $display("[TB] len 0 is ignored");
      applyStimulus(1'b1, 8'hFF, 4'd0);
      for (int j = 1; j <= 5; j++) begin
         stepCycle();
         checkCycle($sformatf("len0[%0d]", j), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 4'd0);
      stepCycle();

      $display("[TB] len 12 clamps to 8");
      pulseStart(8'hFF, 4'd12);
      checkWindow("clamp", 11, 16'b11111111000, 16'b11111111000, 16'b11111111100,
                  16'b00000000100, 16'b00111111100);
      stepCycle();

      $display("[TB] len 1");
      pulseStart(8'h80, 4'd1);
      checkWindow("len1", 4, 16'b1000, 16'b1000, 16'b1100, 16'b0100, 16'b0000);
      stepCycle();

      $display("[TB] start held high, period 4");
      applyStimulus(1'b1, 8'hC0, 4'd2);
      stepCycle();
      checkWindow("held", 11, 16'b11001100110, 16'b11001100110, 16'b11101110111,
                  16'b00100010001, 16'b00100010001);
      applyStimulus(1'b0, 8'h00, 4'd0);
      stepCycle();
      checkCycle("held.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCycle();

      $display("[TB] reset in 4th shift cycle");
      pulseStart(8'hFF, 4'd8);
      stepCycle();
      stepCycle();
      stepCycle();
      checkCycle("prereset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      Reset = 1'b1;
      stepCycle();
      Reset = 1'b0;
      checkCycle("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCycle();
      checkCycle("postreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      pulseStart(8'hFF, 4'd2);
      checkWindow("afterrst", 5, 16'b11000, 16'b11000, 16'b11100, 16'b00100, 16'b00100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
